// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues sequential reads to a
// 1-cycle-latency instruction memory and buffers {pc, instr} pairs for decode.
module fetch_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_rd_en,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam int unsigned     CW      = PW + 1;
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(PC_STEP - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          queue_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic            kill;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] fetch_pc;

    logic            issue;
    logic            push;
    logic            pop;

    // Credit check counts the in-flight response so it always finds a free slot.
    always_comb begin
        issue = reset && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
        push  = inflight && !kill && !redirect;
        pop   = (count != '0) && out_ready && !redirect;
    end

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc;
    assign out_valid  = (count != '0);
    assign out_instr  = queue_mem[rd_ptr].instr;
    assign out_pc     = queue_mem[rd_ptr].pc;
    assign q_count    = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
            fetch_pc    <= RESET_PC;
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_mem[i] <= '0;
            end
        end else if (redirect) begin
            // Flush everything; the response landing next cycle belongs to the old path.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            kill     <= inflight;
            fetch_pc <= redirect_pc & PC_MASK;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
            end
            if (push) begin
                queue_mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A push into a full queue without a matching pop means the credit logic is broken.
    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  q_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] salt = '0;
    logic [31:0] next_pc = '0;

    // Reference model: queue of PCs, one pending response, fetch PC
    logic [31:0] m_q[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = '0;
    logic [31:0] m_pc = RESET_PC;

    fetch_prefetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    // Synchronous instruction memory, 1-cycle read latency
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_f(imem_addr);
    end

    function automatic bit m_rd_en();
        return reset && !redirect && ((m_q.size() + (m_pend ? 1 : 0)) < int'(DEPTH));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_pc      = RESET_PC;
    endtask

    task automatic model_clock();
        bit iss;
        iss = m_rd_en();
        if (!reset) begin
            model_reset();
        end else if (redirect) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = redirect_pc & ~32'(PC_STEP - 1);
        end else begin
            if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (m_pend) m_q.push_back(m_pend_pc);
            m_pend    = iss;
            m_pend_pc = m_pc;
            if (iss) m_pc = m_pc + PC_STEP;
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] rpc, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        drive(0, 0, 0);
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", q_count); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1);
            checks++;
            if (out_valid !== 1'(k >= 2)) begin
                failures++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, out_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (out_pc !== 32'(4 * (k - 2))) begin
                    failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, out_pc, 32'(4 * (k - 2)));
                end
                checks++;
                if (out_instr !== 32'(k - 2)) begin
                    failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, out_instr, 32'(k - 2));
                end
                next_pc = 32'(4 * (k - 1));
            end
            checks++;
            if (imem_rd_en !== m_rd_en()) begin
                failures++; $display("FAIL stream_rd_en k=%0d got=%b exp=%b", k, imem_rd_en, m_rd_en());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0);
            checks++;
            if (q_count !== 3'(m_q.size())) begin
                failures++; $display("FAIL bp_count k=%0d got=%0d exp=%0d", k, q_count, m_q.size());
            end
            checks++;
            if (imem_rd_en !== m_rd_en()) begin
                failures++; $display("FAIL bp_rd_en k=%0d got=%b exp=%b", k, imem_rd_en, m_rd_en());
            end
            tick();
        end
        drive(0, 0, 0);
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL bp_full got=%0d exp=4", q_count); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", imem_rd_en); end
        for (int k = 0; k < 12; k++) begin
            drive(0, 0, 1);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_bubble k=%0d got=%b exp=1", k, out_valid);
            end else begin
                checks++;
                if (out_pc !== next_pc) begin
                    failures++; $display("FAIL bp_contig k=%0d got=%h exp=%h", k, out_pc, next_pc);
                end
                next_pc = next_pc + 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        int got;
        int k;
        k = 0;
        while (!(m_q.size() == 3 && m_pend) && k < 10) begin
            drive(0, 0, 0);
            tick();
            k++;
        end
        checks++; if (k >= 10) begin failures++; $display("FAIL redir_setup_timeout got=%0d exp=<10", k); end
        drive(1, 32'h100, 1);
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%b exp=0", imem_rd_en); end
        tick();
        drive(0, 0, 1);
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL redir_flush got=%0d exp=0", q_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", out_valid); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        got = 0;
        for (int c = 0; c < 8 && got < 2; c++) begin
            drive(0, 0, 1);
            if (out_valid) begin
                checks++;
                if (out_pc !== 32'h100 + 32'(4 * got)) begin
                    failures++; $display("FAIL redir_pc n=%0d got=%h exp=%h", got, out_pc, 32'h100 + 32'(4 * got));
                end
                checks++;
                if (out_instr !== mem_f(32'h100 + 32'(4 * got))) begin
                    failures++; $display("FAIL redir_instr n=%0d got=%h exp=%h", got, out_instr, mem_f(32'h100 + 32'(4 * got)));
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 2) begin failures++; $display("FAIL redir_timeout got=%0d exp=2", got); end
    endtask

    task automatic test_redirect_align();
        bit seen;
        drive(1, 32'h203, 1);
        tick();
        drive(0, 0, 1);
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL align_addr got=%h exp=200", imem_addr); end
        checks++; if (imem_rd_en !== 1'b1) begin failures++; $display("FAIL align_rd_en got=%b exp=1", imem_rd_en); end
        tick();
        drive(1, 32'h40, 1);
        tick();
        drive(1, 32'h80, 1);
        tick();
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            drive(0, 0, 1);
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (out_pc !== 32'h80) begin failures++; $display("FAIL b2b_redir_pc got=%h exp=80", out_pc); end
            end
            tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_redir_timeout got=0 exp=1"); end
    endtask

    task automatic test_wrap();
        logic [31:0] wa [4];
        int got;
        wa[0] = 32'hFFFF_FFF8; wa[1] = 32'hFFFF_FFFC; wa[2] = 32'h0; wa[3] = 32'h4;
        drive(1, 32'hFFFF_FFF8, 1);
        tick();
        got = 0;
        for (int k = 0; k < 10 && got < 4; k++) begin
            drive(0, 0, 1);
            if (k < 3) begin
                checks++;
                if (imem_rd_en !== 1'b1 || imem_addr !== wa[k]) begin
                    failures++; $display("FAIL wrap_addr k=%0d got=%b/%h exp=1/%h", k, imem_rd_en, imem_addr, wa[k]);
                end
            end
            if (out_valid) begin
                checks++;
                if (out_pc !== wa[got]) begin failures++; $display("FAIL wrap_pc n=%0d got=%h exp=%h", got, out_pc, wa[got]); end
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin failures++; $display("FAIL wrap_timeout got=%0d exp=4", got); end
    endtask

    task automatic test_random();
        logic r;
        logic rdy;
        salt = $urandom;
        drive(1, $urandom, 1);
        tick();
        for (int k = 0; k < 300; k++) begin
            r   = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive(r, $urandom, rdy);
            checks++;
            if (imem_rd_en !== m_rd_en()) begin
                failures++; $display("FAIL rand_rd_en k=%0d got=%b exp=%b", k, imem_rd_en, m_rd_en());
            end
            if (m_rd_en()) begin
                checks++;
                if (imem_addr !== m_pc) begin failures++; $display("FAIL rand_addr k=%0d got=%h exp=%h", k, imem_addr, m_pc); end
            end
            checks++;
            if (q_count !== 3'(m_q.size()) || out_valid !== (m_q.size() != 0)) begin
                failures++; $display("FAIL rand_count k=%0d got=%0d/%b exp=%0d", k, q_count, out_valid, m_q.size());
            end
            if (m_q.size() != 0) begin
                checks++;
                if (out_pc !== m_q[0] || out_instr !== mem_f(m_q[0])) begin
                    failures++; $display("FAIL rand_head k=%0d got=%h/%h exp=%h/%h", k, out_pc, out_instr, m_q[0], mem_f(m_q[0]));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        salt = '0;
        drive(1, 32'h300, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0);
            tick();
        end
        drive(0, 0, 0);
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL mid_full got=%0d exp=4", q_count); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", q_count); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", imem_rd_en); end
        model_reset();
        tick();
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1);
            checks++;
            if (out_valid !== 1'(k >= 2)) begin
                failures++; $display("FAIL mid_restart_valid k=%0d got=%b exp=%b", k, out_valid, k >= 2);
            end
            if (k == 2) begin
                checks++;
                if (out_pc !== RESET_PC) begin failures++; $display("FAIL mid_restart_pc got=%h exp=%h", out_pc, RESET_PC); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_align();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
